// File: rtl/quiz_round_arbiter.sv
// Two-player buzzer quiz arbiter: synchronizes the joystick buttons, arbitrates the
// first valid answer, and scores rounds, with lockouts, round timeout and end-of-game detection.
module quiz_round_arbiter #(
  parameter int NUM_Q       = 11,
  parameter int WIN_SCORE   = 5,
  parameter int SHOW_CYC    = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_hex_joy,
  input  logic [3:0] ans,
  output logic [3:0] q_idx,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic [1:0] result,
  output logic       show,
  output logic       lock_p1,
  output logic       lock_p2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int SHOW_W = $clog2(SHOW_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);
  localparam logic [2:0]        WIN_S     = 3'(WIN_SCORE);
  localparam logic [3:0]        Q_LAST    = 4'(NUM_Q - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_PRESS,
    S_JUDGE,
    S_SHOW,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [7:0]          r_sync1;
  logic [7:0]          r_sync2;
  logic [3:0]          r_q_idx;
  logic [2:0]          r_score_p1;
  logic [2:0]          r_score_p2;
  logic [1:0]          r_result;
  logic                r_show;
  logic                r_lock_p1;
  logic                r_lock_p2;
  logic                r_game_over;
  logic [1:0]          r_winner;
  logic                r_prio;      // 0: P1 wins a simultaneous press, 1: P2
  logic                r_pl;        // player under judgement, 0: P1, 1: P2
  logic [3:0]          r_pans;
  logic [TMO_W-1:0]    r_tmo;
  logic [SHOW_W-1:0]   r_show_cnt;

  logic [7:0] w_joy;
  logic [3:0] w_a1;
  logic [3:0] w_a2;
  logic       w_p1ok;
  logic       w_p2ok;
  logic       w_take1;
  logic       w_take2;

  // One-hot-low nibble -> answer 1..4; anything else decodes to 0 (no press).
  function automatic logic [3:0] f_dec(input logic [3:0] nib);
    case (nib)
      4'b0111: f_dec = 4'd1;
      4'b1011: f_dec = 4'd2;
      4'b1101: f_dec = 4'd3;
      4'b1110: f_dec = 4'd4;
      default: f_dec = 4'd0;
    endcase
  endfunction

  always_comb begin
    w_joy   = r_sync2;
    w_a1    = f_dec(w_joy[7:4]);
    w_a2    = f_dec(w_joy[3:0]);
    w_p1ok  = (|w_a1) && !r_lock_p1;
    w_p2ok  = (|w_a2) && !r_lock_p2;
    w_take2 = w_p2ok && (!w_p1ok || r_prio);
    w_take1 = w_p1ok && !w_take2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_q_idx     <= '0;
      r_score_p1  <= '0;
      r_score_p2  <= '0;
      r_result    <= '0;
      r_show      <= 1'b0;
      r_lock_p1   <= 1'b0;
      r_lock_p2   <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= '0;
      r_prio      <= 1'b0;
      r_pl        <= 1'b0;
      r_pans      <= '0;
      r_tmo       <= '0;
      r_show_cnt  <= '0;
    end else begin
      r_sync1 <= in_hex_joy;
      r_sync2 <= r_sync1;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_q_idx     <= '0;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_lock_p1   <= 1'b0;
            r_lock_p2   <= 1'b0;
            r_result    <= '0;
            r_game_over <= 1'b0;
            r_winner    <= '0;
            r_state     <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (&w_joy) begin
            r_tmo   <= '0;
            r_state <= S_WAIT_PRESS;
          end
        end
        S_WAIT_PRESS: begin
          if (w_take1 || w_take2) begin
            r_pl    <= w_take2;
            r_pans  <= w_take2 ? w_a2 : w_a1;
            if (w_p1ok && w_p2ok)
              r_prio <= ~r_prio;
            r_state <= S_JUDGE;
          end else if (r_tmo == TMO_LAST) begin
            r_result   <= 2'b11;
            r_show     <= 1'b1;
            r_show_cnt <= '0;
            r_state    <= S_SHOW;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_JUDGE: begin
          if (r_pans == ans) begin
            if (!r_pl) begin
              if (r_score_p1 < WIN_S)
                r_score_p1 <= r_score_p1 + 1'b1;
              r_result <= 2'b01;
            end else begin
              if (r_score_p2 < WIN_S)
                r_score_p2 <= r_score_p2 + 1'b1;
              r_result <= 2'b10;
            end
            r_show     <= 1'b1;
            r_show_cnt <= '0;
            r_state    <= S_SHOW;
          end else begin
            if (!r_pl)
              r_lock_p1 <= 1'b1;
            else
              r_lock_p2 <= 1'b1;
            // Second wrong answer locks both players and closes the round.
            if (r_pl ? r_lock_p1 : r_lock_p2) begin
              r_result   <= 2'b11;
              r_show     <= 1'b1;
              r_show_cnt <= '0;
              r_state    <= S_SHOW;
            end else begin
              r_state <= S_WAIT_PRESS;
            end
          end
        end
        S_SHOW: begin
          if (r_show_cnt == SHOW_LAST) begin
            r_show  <= 1'b0;
            r_state <= S_NEXT;
          end else begin
            r_show_cnt <= r_show_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          r_lock_p1 <= 1'b0;
          r_lock_p2 <= 1'b0;
          r_result  <= '0;
          if (r_score_p1 == WIN_S || r_score_p2 == WIN_S || r_q_idx == Q_LAST) begin
            r_game_over <= 1'b1;
            if (r_score_p1 > r_score_p2)
              r_winner <= 2'b01;
            else if (r_score_p1 < r_score_p2)
              r_winner <= 2'b10;
            else
              r_winner <= 2'b11;
            r_state <= S_DONE;
          end else begin
            r_q_idx <= r_q_idx + 1'b1;
            r_state <= S_ARMED;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q_idx     = r_q_idx;
  assign score_p1  = r_score_p1;
  assign score_p2  = r_score_p2;
  assign result    = r_result;
  assign show      = r_show;
  assign lock_p1   = r_lock_p1;
  assign lock_p2   = r_lock_p2;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_quiz_round_arbiter.sv
// Directed bench for quiz_round_arbiter with hand-computed expectations.
module tb_quiz_round_arbiter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in_hex_joy;
  logic [3:0] ans;
  logic [3:0] q_idx;
  logic [2:0] score_p1;
  logic [2:0] score_p2;
  logic [1:0] result;
  logic       show;
  logic       lock_p1;
  logic       lock_p2;
  logic       game_over;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;

  quiz_round_arbiter #(
    .NUM_Q(11),
    .WIN_SCORE(5),
    .SHOW_CYC(8),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_hex_joy(in_hex_joy),
    .ans(ans),
    .q_idx(q_idx),
    .score_p1(score_p1),
    .score_p2(score_p2),
    .result(result),
    .show(show),
    .lock_p1(lock_p1),
    .lock_p2(lock_p2),
    .game_over(game_over),
    .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_q"},     8'(q_idx),     8'd0);
    chk({tag, "_s1"},    8'(score_p1),  8'd0);
    chk({tag, "_s2"},    8'(score_p2),  8'd0);
    chk({tag, "_res"},   8'(result),    8'd0);
    chk({tag, "_show"},  8'(show),      8'd0);
    chk({tag, "_l1"},    8'(lock_p1),   8'd0);
    chk({tag, "_l2"},    8'(lock_p2),   8'd0);
    chk({tag, "_over"},  8'(game_over), 8'd0);
    chk({tag, "_win"},   8'(winner),    8'd0);
  endtask

  // Let SHOW run out (bounded), then step through NEXT.
  task automatic next_q();
    int n = 0;
    while (show === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("show_fall", 8'(show), 8'd0);
    tick();
  endtask

  // One full round from ARMED: press, wait for SHOW, check result, release, advance.
  task automatic play(input logic [7:0] pat, input logic [3:0] a, input logic [1:0] exp_res);
    int n = 0;
    ans = a;
    in_hex_joy = pat;
    while (show !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("play_show", 8'(show), 8'd1);
    chk("play_res", 8'(result), 8'(exp_res));
    in_hex_joy = 8'hFF;
    next_q();
  endtask

  initial begin
    int n;
    logic [7:0] pats [11];
    logic [3:0] anss [11];
    logic [1:0] ress [11];

    rst = 1'b1;
    start = 1'b0;
    in_hex_joy = 8'hFF;
    ans = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_state("rst");

    // Round 1: P1 answers 2 correctly, 4-cycle input-to-score latency
    ans = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r1_q0", 8'(q_idx), 8'd0);
    tick();
    in_hex_joy = 8'b1011_1111;
    tick(); tick(); tick();
    chk("r1_show_early", 8'(show), 8'd0);
    tick();
    chk("r1_s1", 8'(score_p1), 8'd1);
    chk("r1_s2", 8'(score_p2), 8'd0);
    chk("r1_res", 8'(result), 8'd1);
    chk("r1_show", 8'(show), 8'd1);
    in_hex_joy = 8'hFF;
    n = 0;
    while (show === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("r1_show_len", 8'(n), 8'd8);
    tick();
    chk("r1_q1", 8'(q_idx), 8'd1);
    chk("r1_res_clr", 8'(result), 8'd0);

    // Round 2: P1 wrong -> locked, locked presses ignored, P2 answers 3
    ans = 4'd3;
    in_hex_joy = 8'b0111_1111;
    repeat (4) tick();
    chk("r2_l1", 8'(lock_p1), 8'd1);
    chk("r2_l2", 8'(lock_p2), 8'd0);
    chk("r2_s1", 8'(score_p1), 8'd1);
    chk("r2_res0", 8'(result), 8'd0);
    in_hex_joy = 8'b1011_1111;
    repeat (6) tick();
    chk("r2_locked_ign", 8'(show), 8'd0);
    in_hex_joy = 8'b1011_1101;
    repeat (4) tick();
    chk("r2_s2", 8'(score_p2), 8'd1);
    chk("r2_s1b", 8'(score_p1), 8'd1);
    chk("r2_res", 8'(result), 8'd2);
    chk("r2_show", 8'(show), 8'd1);
    in_hex_joy = 8'hFF;
    next_q();
    chk("r2_q2", 8'(q_idx), 8'd2);
    chk("r2_l1_clr", 8'(lock_p1), 8'd0);

    // Rounds 3-4: simultaneous presses, priority P1 then P2
    ans = 4'd1;
    in_hex_joy = 8'b0111_0111;
    repeat (4) tick();
    chk("tie1_s1", 8'(score_p1), 8'd2);
    chk("tie1_res", 8'(result), 8'd1);
    in_hex_joy = 8'hFF;
    next_q();
    chk("tie1_q3", 8'(q_idx), 8'd3);
    in_hex_joy = 8'b0111_0111;
    repeat (4) tick();
    chk("tie2_s2", 8'(score_p2), 8'd2);
    chk("tie2_s1", 8'(score_p1), 8'd2);
    chk("tie2_res", 8'(result), 8'd2);
    next_q();
    chk("tie2_q4", 8'(q_idx), 8'd4);

    // Round 5: held buttons block ARMED, then 64-cycle timeout
    repeat (10) tick();
    chk("hold_show", 8'(show), 8'd0);
    chk("hold_s1", 8'(score_p1), 8'd2);
    chk("hold_s2", 8'(score_p2), 8'd2);
    in_hex_joy = 8'hFF;
    repeat (66) tick();
    chk("tmo_early", 8'(show), 8'd0);
    tick();
    chk("tmo_show", 8'(show), 8'd1);
    chk("tmo_res", 8'(result), 8'd3);
    chk("tmo_s1", 8'(score_p1), 8'd2);
    chk("tmo_s2", 8'(score_p2), 8'd2);
    next_q();
    chk("tmo_q5", 8'(q_idx), 8'd5);
    chk("tmo_res_clr", 8'(result), 8'd0);

    // start mid-game is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_q", 8'(q_idx), 8'd5);
    chk("ign_s1", 8'(score_p1), 8'd2);

    // Reset during SHOW
    ans = 4'd1;
    in_hex_joy = 8'b0111_1111;
    n = 0;
    while (show !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("pre_rst_s1", 8'(score_p1), 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_hex_joy = 8'hFF;
    chk_reset_state("midrst");

    // New game: P1 takes 5 straight
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("g2_q0", 8'(q_idx), 8'd0);
    repeat (4) play(8'b0111_1111, 4'd1, 2'b01);
    chk("g2_not_over", 8'(game_over), 8'd0);
    chk("g2_q4", 8'(q_idx), 8'd4);
    play(8'b0111_1111, 4'd1, 2'b01);
    chk("g2_over", 8'(game_over), 8'd1);
    chk("g2_win", 8'(winner), 8'd1);
    chk("g2_qheld", 8'(q_idx), 8'd4);
    chk("g2_s1", 8'(score_p1), 8'd5);
    chk("g2_s2", 8'(score_p2), 8'd0);

    // Restart from DONE: 11 questions, 4-4 split with 3 double-wrong rounds
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("g3_over0", 8'(game_over), 8'd0);
    chk("g3_win0", 8'(winner), 8'd0);
    chk("g3_s1", 8'(score_p1), 8'd0);
    for (int i = 0; i < 11; i++) begin
      case (i % 3)
        0:       begin pats[i] = 8'b0111_1111; anss[i] = 4'd1; ress[i] = 2'b01; end
        1:       begin pats[i] = 8'b1111_0111; anss[i] = 4'd1; ress[i] = 2'b10; end
        default: begin pats[i] = 8'b0111_0111; anss[i] = 4'd2; ress[i] = 2'b11; end
      endcase
    end
    for (int i = 0; i < 11; i++)
      play(pats[i], anss[i], ress[i]);
    chk("g3_q10", 8'(q_idx), 8'd10);
    chk("g3_over", 8'(game_over), 8'd1);
    chk("g3_win", 8'(winner), 8'd3);
    chk("g3_s1f", 8'(score_p1), 8'd4);
    chk("g3_s2f", 8'(score_p2), 8'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
